// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the external memory-port arbiter.
package mem_arbiter_pkg;

    typedef logic [31:0] regval_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_READ,
        RESPOND
    } arb_state_t;

    localparam int ReqFetch = 0;
    localparam int ReqRead  = 1;
    localparam int ReqWrite = 2;

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Combinational priority picker: starved requesters first, then highest index.
module mem_arbiter_arb_select #(
    parameter int NR_REQ = 3,
    parameter int IDX_W  = 2
) (
    input  logic [NR_REQ-1:0] enable,
    input  logic [NR_REQ-1:0] starved,
    output logic [NR_REQ-1:0] grant,
    output logic [IDX_W-1:0]  index
);

    logic [NR_REQ-1:0] starved_enabled;
    logic [NR_REQ-1:0] pool;

    assign starved_enabled = enable & starved;
    // Only fall back to plain priority when nobody pending is starved.
    assign pool = (|starved_enabled) ? starved_enabled : enable;

    always_comb begin
        grant = '0;
        index = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (pool[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                index    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory port between fetch, load and store requesters,
// one transaction at a time, with fixed priority plus a starvation override.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NR_REQ       = 3,
    parameter int STARVE_LIMIT = 4,
    parameter int WIDTH        = $bits(regval_t)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NR_REQ-1:0]              req_enable,
    input  logic [NR_REQ-1:0]              req_write,
    input  logic [NR_REQ-1:0][WIDTH-1:0]   req_address,
    input  logic [NR_REQ-1:0][WIDTH-1:0]   req_data,
    output logic [NR_REQ-1:0]              rsp_valid,
    output logic [WIDTH-1:0]               rsp_data,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [WIDTH-1:0]               mem_address,
    output logic [WIDTH-1:0]               mem_writedata,
    input  logic                           mem_waitrequest,
    input  logic                           mem_readdatavalid,
    input  logic [WIDTH-1:0]               mem_readdata
);

    localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [NR_REQ-1:0] ONE   = NR_REQ'(1);

    arb_state_t        state_reg;
    logic [IDX_W-1:0]  grant_reg;
    logic              write_reg;
    logic              aborted_reg;
    logic [NR_REQ-1:0] starved;
    logic [NR_REQ-1:0] sel_grant;
    logic [IDX_W-1:0]  sel_index;
    logic [NR_REQ-1:0] grant_onehot;
    logic              abort_now;

    mem_arbiter_arb_select #(
        .NR_REQ (NR_REQ),
        .IDX_W  (IDX_W)
    ) u_select (
        .enable  (req_enable),
        .starved (starved),
        .grant   (sel_grant),
        .index   (sel_index)
    );

    assign grant_onehot = ONE << grant_reg;
    // A granted requester that drops its enable mid-transaction loses its response.
    assign abort_now = aborted_reg | ~req_enable[grant_reg];

    for (genvar gi = 0; gi < NR_REQ; gi++) begin : g_starve
        logic [CNT_W-1:0] count_reg;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                count_reg <= '0;
            end else if (!req_enable[gi]) begin
                count_reg <= '0;
            end else if (state_reg == IDLE) begin
                if (sel_grant[gi]) begin
                    count_reg <= '0;
                end else if (count_reg < LIMIT) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
        end

        assign starved[gi] = (count_reg >= LIMIT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            write_reg     <= 1'b0;
            aborted_reg   <= 1'b0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
        end else begin
            rsp_valid <= '0;
            case (state_reg)
                IDLE: begin
                    if (|req_enable) begin
                        grant_reg     <= sel_index;
                        write_reg     <= req_write[sel_index];
                        aborted_reg   <= 1'b0;
                        mem_address   <= req_address[sel_index];
                        mem_writedata <= req_data[sel_index];
                        mem_write     <= req_write[sel_index];
                        mem_read      <= ~req_write[sel_index];
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    aborted_reg <= abort_now;
                    if (!mem_waitrequest) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (write_reg) begin
                            rsp_valid <= abort_now ? '0 : grant_onehot;
                            state_reg <= RESPOND;
                        end else if (mem_readdatavalid) begin
                            if (!abort_now) begin
                                rsp_valid <= grant_onehot;
                                rsp_data  <= mem_readdata;
                            end
                            state_reg <= RESPOND;
                        end else begin
                            state_reg <= WAIT_READ;
                        end
                    end
                end
                WAIT_READ: begin
                    aborted_reg <= abort_now;
                    if (mem_readdatavalid) begin
                        if (!abort_now) begin
                            rsp_valid <= grant_onehot;
                            rsp_data  <= mem_readdata;
                        end
                        state_reg <= RESPOND;
                    end
                end
                RESPOND: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small memory responder and command/response scoreboards.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NR = 3;
    localparam int W  = 32;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic [NR-1:0]       req_enable;
    logic [NR-1:0]       req_write;
    logic [NR-1:0][W-1:0] req_address;
    logic [NR-1:0][W-1:0] req_data;
    logic [NR-1:0]       rsp_valid;
    logic [W-1:0]        rsp_data;
    logic                mem_read;
    logic                mem_write;
    logic [W-1:0]        mem_address;
    logic [W-1:0]        mem_writedata;
    logic                mem_waitrequest;
    logic                mem_readdatavalid;
    logic [W-1:0]        mem_readdata;

    mem_arbiter #(.NR_REQ(NR), .STARVE_LIMIT(4), .WIDTH(W)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req_enable        (req_enable),
        .req_write         (req_write),
        .req_address       (req_address),
        .req_data          (req_data),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_address       (mem_address),
        .mem_writedata     (mem_writedata),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_readdata      (mem_readdata)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: wait_cfg stall cycles per command, load data lat_cfg cycles after acceptance.
    int           wait_cfg = 0;
    int           lat_cfg  = 1;
    int           wcnt     = 0;
    int           rcnt     = 0;
    bit           rd_pend  = 1'b0;
    logic [W-1:0] rd_addr  = '0;
    logic         cmd;

    function automatic logic [W-1:0] rd_fn(input logic [W-1:0] a);
        return a ^ 32'h0F0F_0000;
    endfunction

    assign cmd               = mem_read | mem_write;
    assign mem_waitrequest   = cmd && (wcnt < wait_cfg);
    assign mem_readdatavalid = rd_pend ? (rcnt == 0) : (lat_cfg == 0 && mem_read && !mem_waitrequest);
    assign mem_readdata      = rd_fn(rd_pend ? rd_addr : mem_address);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wcnt    <= 0;
            rcnt    <= 0;
            rd_pend <= 1'b0;
        end else begin
            wcnt <= (cmd && mem_waitrequest) ? wcnt + 1 : 0;
            if (rd_pend) begin
                if (rcnt == 0) rd_pend <= 1'b0;
                else           rcnt    <= rcnt - 1;
            end else if (mem_read && !mem_waitrequest && lat_cfg > 0) begin
                rd_pend <= 1'b1;
                rcnt    <= lat_cfg - 1;
                rd_addr <= mem_address;
            end
        end
    end

    // Scoreboards: expected bus commands and responses, in the order they must appear.
    typedef struct packed { logic wr; logic [W-1:0] addr; logic [W-1:0] data; } cmd_t;
    typedef struct packed { logic [NR-1:0] valid; logic [W-1:0] data; logic chk; } rsp_t;
    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];
    cmd_t mon_got;
    cmd_t mon_exp;
    rsp_t rsp_exp;

    always @(negedge clock) begin
        if (reset_n && cmd && !mem_waitrequest) begin
            mon_got = {mem_write, mem_address, mem_write ? mem_writedata : 32'h0};
            check("cmd_expected", exp_cmd.size() > 0, 1);
            if (exp_cmd.size() > 0) begin
                mon_exp = exp_cmd.pop_front();
                check("cmd_accept", mon_got, mon_exp);
            end
        end
        if (reset_n && rsp_valid != '0) begin
            check("rsp_expected", exp_rsp.size() > 0, 1);
            if (exp_rsp.size() > 0) begin
                rsp_exp = exp_rsp.pop_front();
                check("rsp_valid", rsp_valid, rsp_exp.valid);
                if (rsp_exp.chk) check("rsp_data", rsp_data, rsp_exp.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_rsp(input int idx, input bit drop, output int at);
        at = -1;
        for (int k = 0; k < 50; k++) begin
            tick(1);
            if (rsp_valid[idx]) begin
                at = cyc;
                if (drop) req_enable[idx] = 1'b0;
                break;
            end
        end
        check($sformatf("rsp%0d_seen", idx), at >= 0, 1);
    endtask

    initial begin
        int t0;
        int a0;
        int a1;
        int a2;

        req_enable  = '0;
        req_write   = '0;
        req_address = '0;
        req_data    = '0;

        // Reset state
        tick(3);
        check("reset_cmd", {mem_read, mem_write, mem_address, mem_writedata}, '0);
        check("reset_rsp", {rsp_valid, rsp_data}, '0);
        reset_n = 1'b1;
        tick(2);

        // Store only: command at cycle 1, response at cycle 2
        t0 = cyc;
        req_write[ReqWrite]   = 1'b1;
        req_address[ReqWrite] = 32'h100;
        req_data[ReqWrite]    = 32'hCAFE;
        req_enable            = 3'b100;
        exp_cmd.push_back('{wr: 1'b1, addr: 32'h100, data: 32'hCAFE});
        exp_rsp.push_back('{valid: 3'b100, data: '0, chk: 1'b0});
        tick(1);
        check("store_cmd", {mem_read, mem_write, mem_address, mem_writedata}, {1'b0, 1'b1, 32'h100, 32'hCAFE});
        tick(1);
        check("store_rsp_cycle2", rsp_valid, 3'b100);
        req_enable = '0;
        tick(1);
        check("store_rsp_one_cycle", {rsp_valid, mem_read, mem_write}, '0);
        tick(2);

        // Simultaneous fetch + load + store: write, read, fetch with an idle cycle between
        req_write   = 3'b100;
        req_address = {32'h200, 32'h300, 32'h400};
        req_data    = {32'h1111_2222, 32'h0, 32'h0};
        t0 = cyc;
        req_enable  = 3'b111;
        exp_cmd.push_back('{wr: 1'b1, addr: 32'h200, data: 32'h1111_2222});
        exp_cmd.push_back('{wr: 1'b0, addr: 32'h300, data: 32'h0});
        exp_cmd.push_back('{wr: 1'b0, addr: 32'h400, data: 32'h0});
        exp_rsp.push_back('{valid: 3'b100, data: '0, chk: 1'b0});
        exp_rsp.push_back('{valid: 3'b010, data: rd_fn(32'h300), chk: 1'b1});
        exp_rsp.push_back('{valid: 3'b001, data: rd_fn(32'h400), chk: 1'b1});
        wait_rsp(ReqWrite, 1'b1, a2);
        check("mix_store_latency", a2 - t0, 2);
        wait_rsp(ReqRead, 1'b1, a1);
        check("mix_read_gap", a1 - a2, 4);
        wait_rsp(ReqFetch, 1'b1, a0);
        check("mix_fetch_gap", a0 - a1, 4);
        tick(2);

        // Starvation: fetch and read both held; fetch must win after four read grants
        req_write   = '0;
        req_address = {32'h0, 32'h3000, 32'h2000};
        req_enable  = 3'b011;
        for (int i = 0; i < 4; i++) begin
            exp_cmd.push_back('{wr: 1'b0, addr: 32'h3000, data: 32'h0});
            exp_rsp.push_back('{valid: 3'b010, data: rd_fn(32'h3000), chk: 1'b1});
        end
        exp_cmd.push_back('{wr: 1'b0, addr: 32'h2000, data: 32'h0});
        exp_rsp.push_back('{valid: 3'b001, data: rd_fn(32'h2000), chk: 1'b1});
        for (int i = 0; i < 4; i++) wait_rsp(ReqRead, 1'b0, a1);
        wait_rsp(ReqFetch, 1'b1, a0);
        req_enable = '0;
        check("starve_fetch_gap", a0 - a1, 4);
        tick(2);

        // Load with 3 stall cycles, data 2 cycles after acceptance
        wait_cfg = 3;
        lat_cfg  = 2;
        req_address[ReqRead] = 32'h0F0F_1234;
        t0 = cyc;
        req_enable = 3'b010;
        exp_cmd.push_back('{wr: 1'b0, addr: 32'h0F0F_1234, data: 32'h0});
        exp_rsp.push_back('{valid: 3'b010, data: 32'h1234, chk: 1'b1});
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("load_cmd_stable%0d", i), {mem_read, mem_write, mem_address}, {1'b1, 1'b0, 32'h0F0F_1234});
        end
        tick(1);
        check("load_cmd_drop", {mem_read, mem_write}, 2'b00);
        wait_rsp(ReqRead, 1'b1, a1);
        check("load_latency", a1 - t0, 7);
        check("load_data", rsp_data, 32'h1234);
        tick(3);
        check("rsp_data_hold", rsp_data, 32'h1234);
        wait_cfg = 0;

        // Load data in the same cycle as acceptance: 2-cycle turnaround
        lat_cfg = 0;
        req_address[ReqFetch] = 32'h40;
        t0 = cyc;
        req_enable = 3'b001;
        exp_cmd.push_back('{wr: 1'b0, addr: 32'h40, data: 32'h0});
        exp_rsp.push_back('{valid: 3'b001, data: rd_fn(32'h40), chk: 1'b1});
        wait_rsp(ReqFetch, 1'b1, a0);
        check("load_same_cycle_latency", a0 - t0, 2);
        tick(2);

        // Abort: read drops its request during WAIT_READ; bus completes silently, fetch follows
        lat_cfg = 3;
        req_address = {32'h0, 32'h500, 32'h600};
        t0 = cyc;
        req_enable = 3'b011;
        exp_cmd.push_back('{wr: 1'b0, addr: 32'h500, data: 32'h0});
        exp_cmd.push_back('{wr: 1'b0, addr: 32'h600, data: 32'h0});
        exp_rsp.push_back('{valid: 3'b001, data: rd_fn(32'h600), chk: 1'b1});
        tick(2);
        check("abort_waitread_nocmd", {mem_read, mem_write}, 2'b00);
        req_enable[ReqRead] = 1'b0;
        wait_rsp(ReqFetch, 1'b1, a0);
        check("abort_fetch_latency", a0 - t0, 11);
        lat_cfg = 1;
        tick(2);

        // Asynchronous reset while a store is stalled in ISSUE
        wait_cfg = 100;
        req_write   = 3'b100;
        req_address = {32'h700, 32'h0, 32'h0};
        req_data    = {32'hBEEF, 32'h0, 32'h0};
        req_enable  = 3'b100;
        tick(2);
        check("stall_cmd", {mem_read, mem_write, mem_address}, {1'b0, 1'b1, 32'h700});
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_cmd", {mem_read, mem_write, mem_address, mem_writedata}, '0);
        check("async_reset_rsp", {rsp_valid, rsp_data}, '0);
        req_enable = '0;
        wait_cfg   = 0;
        tick(1);
        reset_n = 1'b1;
        tick(3);
        check("post_reset_idle", {rsp_valid, mem_read, mem_write}, '0);

        check("cmd_queue_drained", exp_cmd.size(), 0);
        check("rsp_queue_drained", exp_rsp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external memory port between fetch (instruction read), read stage (data load) and write stage (data store).
- Exactly one transaction is outstanding at a time.
- Fixed priority is write > read > fetch, with a starvation override so fetch cannot be locked out by back-to-back loads and stores.
- Each requester sees a level-request / single-cycle-response handshake that matches the write stage's address_enable / data_valid pair.

Parameters:
NR_REQ, 3, number of requesters; index 0 = fetch, 1 = read, 2 = write; a higher index has higher base priority
STARVE_LIMIT, 4, number of consecutive lost arbitrations after which a pending requester is promoted
WIDTH, 32, address and data width (matches regval_t)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_enable  in  NR_REQ  per-requester request level; held until rsp_valid
req_write  in  NR_REQ  1 = store, 0 = load
req_address  in  NR_REQ x WIDTH  per-requester address
req_data  in  NR_REQ x WIDTH  per-requester store data
rsp_valid  out  NR_REQ  one-cycle completion pulse to the granted requester
rsp_data  out  WIDTH  load data, valid with rsp_valid
mem_read  out  1  memory read command
mem_write  out  1  memory write command
mem_address  out  WIDTH  memory address
mem_writedata  out  WIDTH  memory store data
mem_waitrequest  in  1  memory stall; the command is accepted in a cycle where it is low
mem_readdatavalid  in  1  load data present on mem_readdata
mem_readdata  in  WIDTH  load data

Behaviour:
- Reset (asynchronous, any state): state = IDLE; all outputs 0; grant = 0; starve counters = 0.
- States:
  - IDLE: no command driven.
  - ISSUE: mem_read or mem_write driven from the registered address/data/grant.
  - WAIT_READ: load accepted, awaiting data.
  - RESPOND: rsp_valid[grant] = 1.
- IDLE transitions:
  - If any req_enable is high, select a winner.
  - Register address, data, write flag and grant index.
  - Go to ISSUE. The command appears one cycle after the request is first seen.
- Winner selection:
  - Requesters with starve count >= STARVE_LIMIT win over all others.
  - Within each class, the highest index wins.
- ISSUE transitions:
  - Command outputs stay stable while mem_waitrequest = 1.
  - When mem_waitrequest = 0: a store goes to RESPOND; a load goes to WAIT_READ.
  - Command outputs deassert in the cycle after acceptance.
- WAIT_READ transitions:
  - On mem_readdatavalid, register mem_readdata into rsp_data and go to RESPOND.
  - mem_readdatavalid arriving in the same cycle as load acceptance is legal: go straight to RESPOND with that data.
- RESPOND:
  - rsp_valid[grant] is high for exactly one cycle.
  - rsp_data holds its value until the next load response.
  - The next state is always IDLE. This guarantees one idle cycle so a requester whose enable is still high from the completed access is never re-granted.
- Abort:
  - If req_enable[grant] falls before RESPOND (for example, a pipeline flush), the bus transaction still completes.
  - rsp_valid is suppressed for that transaction, and the FSM returns to IDLE.
- Starve counters (per requester):
  - Increment, saturating at STARVE_LIMIT, on each IDLE arbitration where the requester is enabled and loses.
  - Clear on grant, or whenever req_enable is low.
- Requests arriving in non-IDLE states are ignored until the next IDLE. req_* inputs are sampled only in IDLE.
- Store-over-load hazard: write has base priority, so a store and a load presented in the same IDLE cycle always issue store first.
- Worst-case latency (zero wait states):
  - Store: request to rsp_valid = 2 cycles.
  - Load: 3 cycles.

Decomposition:
- Shared package:
  - state enum arb_state_t {IDLE, ISSUE, WAIT_READ, RESPOND}.
  - Requester index constants ReqFetch = 0, ReqRead = 1, ReqWrite = 2.
  - Reuse regval_t.
- Sub-module arb_select: combinational priority picker taking enable and starved vectors and returning a one-hot grant plus the grant index. Verified standalone.

Test Plan:
- Reset mid-ISSUE with mem_waitrequest = 1 → all outputs 0 the same cycle; after release, IDLE with no spurious command.
- Store only: req_enable = 3'b100, address 0x100, data 0xCAFE, waitrequest low → mem_write = 1 with 0x100/0xCAFE at cycle 1; rsp_valid = 3'b100 at cycle 2.
- Simultaneous fetch + load + store → grants in order write, read, fetch; each rsp_valid one cycle; one IDLE cycle between transactions.
- Starvation: hold fetch and read enabled, and re-raise read immediately after each response → fetch is granted after 4 read grants (STARVE_LIMIT = 4).
- Load with waitrequest held 3 cycles and readdatavalid 2 cycles after acceptance, data 0x1234 → command stable 4 cycles; rsp_data = 0x1234 with rsp_valid[1].
- Abort: drop req_enable[1] during WAIT_READ → load completes on the bus, no rsp_valid; the next pending fetch is granted afterwards.
